// File: rtl/dp_pkg.sv
// Shared definitions for the byte-serial datapath link: FSM state
// encoding, default operand width and the order of output symbols.
package dp_pkg;

  localparam int DP_WIDTH = 8;

  // One state per received operand, one for the result register load,
  // and one per emitted result symbol.
  typedef enum logic [2:0] {
    GET_A   = 3'd0,
    GET_B   = 3'd1,
    GET_C   = 3'd2,
    CALC    = 3'd3,
    SEND_XH = 3'd4,
    SEND_XL = 3'd5,
    SEND_Z  = 3'd6
  } dp_state_e;

  // Output symbols leave in this order: high half of x, low half of x, z.
  localparam logic [1:0] SYM_XH = 2'd0;
  localparam logic [1:0] SYM_XL = 2'd1;
  localparam logic [1:0] SYM_Z  = 2'd2;

endpackage

// File: rtl/dp_core_comb.sv
// Purely combinational add/compare/multiply/subtract datapath.
// All arithmetic is unsigned and wraps modulo the destination width.
module dp_core_comb
  import dp_pkg::*;
#(
  parameter int WIDTH = DP_WIDTH
) (
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  input  logic [WIDTH-1:0]   c_i,
  output logic [2*WIDTH-1:0] x_o,
  output logic [WIDTH-1:0]   z_o
);

  logic [WIDTH-1:0]   sumAb;
  logic [WIDTH-1:0]   sumAc;
  logic               abGreater;
  logic [2*WIDTH-1:0] prodAc;

  // Sums wrap at WIDTH bits; the larger one is kept, with a tie going to a+c.
  // The product is full width and the a+b sum is zero-extended before the subtract.
  always_comb begin
    sumAb     = a_i + b_i;
    sumAc     = a_i + c_i;
    abGreater = (sumAb > sumAc);
    prodAc    = {{WIDTH{1'b0}}, a_i} * {{WIDTH{1'b0}}, c_i};
    z_o       = abGreater ? sumAb : sumAc;
    x_o       = prodAc - {{WIDTH{1'b0}}, sumAb};
  end

endmodule

// File: rtl/dp_byte_link.sv
// Byte-serial wrapper around dp_core_comb: collects a, b, c over a
// valid/ready input stream, registers the results for one cycle, then
// streams x (high, low) and z out over a valid/ready output stream.
// Only one frame is in flight; input is refused while results drain.
module dp_byte_link
  import dp_pkg::*;
#(
  parameter int WIDTH = DP_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             frame_done
);

  dp_state_e          state_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   c_q;
  logic [2*WIDTH-1:0] x_q;
  logic [WIDTH-1:0]   z_q;

  logic               inReady_q;
  logic               outValid_q;
  logic [WIDTH-1:0]   outData_q;
  logic               busy_q;

  logic [2*WIDTH-1:0] x_d;
  logic [WIDTH-1:0]   z_d;
  logic               inXfer;
  logic               outXfer;

  dp_core_comb #(
    .WIDTH(WIDTH)
  ) u_core (
    .a_i(a_q),
    .b_i(b_q),
    .c_i(c_q),
    .x_o(x_d),
    .z_o(z_d)
  );

  // Select one output symbol from the result pair by its position in the frame.
  function automatic logic [WIDTH-1:0] pickSym(input logic [2*WIDTH-1:0] x,
                                               input logic [WIDTH-1:0]   z,
                                               input logic [1:0]         sel);
    logic [WIDTH-1:0] sym;
    sym = '0;
    case (sel)
      SYM_XH:  sym = x[2*WIDTH-1:WIDTH];
      SYM_XL:  sym = x[WIDTH-1:0];
      SYM_Z:   sym = z;
      default: sym = '0;
    endcase
    return sym;
  endfunction

  assign inXfer  = in_valid && inReady_q;
  assign outXfer = out_ready && outValid_q;

  // Frame sequencer: operands are latched on input handshakes, results
  // are captured in CALC, and each output symbol is preloaded into the
  // output register on the transition that exposes it, so out_data
  // cannot change while the sink is stalling.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= GET_A;
      a_q        <= '0;
      b_q        <= '0;
      c_q        <= '0;
      x_q        <= '0;
      z_q        <= '0;
      inReady_q  <= 1'b1;
      outValid_q <= 1'b0;
      outData_q  <= '0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        GET_A: begin
          if (inXfer) begin
            a_q     <= in_data;
            busy_q  <= 1'b1;
            state_q <= GET_B;
          end
        end
        GET_B: begin
          if (inXfer) begin
            b_q     <= in_data;
            state_q <= GET_C;
          end
        end
        GET_C: begin
          if (inXfer) begin
            c_q       <= in_data;
            inReady_q <= 1'b0;
            state_q   <= CALC;
          end
        end
        CALC: begin
          x_q        <= x_d;
          z_q        <= z_d;
          outValid_q <= 1'b1;
          outData_q  <= pickSym(x_d, z_d, SYM_XH);
          state_q    <= SEND_XH;
        end
        SEND_XH: begin
          if (outXfer) begin
            outData_q <= pickSym(x_q, z_q, SYM_XL);
            state_q   <= SEND_XL;
          end
        end
        SEND_XL: begin
          if (outXfer) begin
            outData_q <= pickSym(x_q, z_q, SYM_Z);
            state_q   <= SEND_Z;
          end
        end
        SEND_Z: begin
          if (outXfer) begin
            outValid_q <= 1'b0;
            outData_q  <= '0;
            inReady_q  <= 1'b1;
            busy_q     <= 1'b0;
            state_q    <= GET_A;
          end
        end
        default: begin
          inReady_q  <= 1'b1;
          outValid_q <= 1'b0;
          outData_q  <= '0;
          busy_q     <= 1'b0;
          state_q    <= GET_A;
        end
      endcase
    end
  end

  assign in_ready  = inReady_q;
  assign out_valid = outValid_q;
  assign out_data  = outData_q;
  assign busy      = busy_q;

  // The frame completes in the same cycle the last symbol is handed off.
  assign frame_done = (state_q == SEND_Z) && out_ready;

endmodule

// File: doc/dp_byte_link.md
Name: dp_byte_link

Overview:
- Byte-serial front/back end for the team's add/compare/multiply/subtract datapath.
- Accepts operand bytes a, b, c over a valid/ready input stream, computes the datapath results, and returns them as a byte stream over a valid/ready output.
- Sits between the board-level byte interface (UART/host FIFO) and the datapath, so the datapath can be exercised without wide parallel ports.
- Processes one frame at a time: 3 bytes in, 3 bytes out.

Parameters:
- WIDTH, 8, operand width in bits; in/out stream symbol width; x result is 2*WIDTH.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_data  input  WIDTH  operand symbol
- in_valid  input  1  in_data valid
- in_ready  output  1  block accepts in_data this cycle
- out_data  output  WIDTH  result symbol
- out_valid  output  1  out_data valid
- out_ready  input  1  sink accepts out_data this cycle
- busy  output  1  frame in progress (any state except GET_A)
- frame_done  output  1  one-cycle pulse when the last output symbol is accepted

Behaviour:
- Clock and reset: one clock, clk; reset rst is asynchronous and active-high.
- Reset values:
  - state=GET_A; in_ready=1; out_valid=0; out_data=0; busy=0; frame_done=0.
  - Operand registers a, b, c and result registers x, z are 0.
- Transfer rule: a symbol transfers when valid&&ready on a rising clk edge. Holding valid without ready is legal and repeats nothing.
- FSM states: GET_A, GET_B, GET_C, CALC, SEND_XH, SEND_XL, SEND_Z.
  - GET_A/GET_B/GET_C: in_ready=1. On transfer, latch the operand and advance to the next state; with no transfer, stay.
  - CALC: in_ready=0, exactly one cycle. Register results, then go to SEND_XH.
  - SEND_XH: out_data=x[2W-1:W], out_valid=1.
  - SEND_XL: out_data=x[W-1:0], out_valid=1.
  - SEND_Z: out_data=z, out_valid=1.
  - Each SEND state advances only on out_ready. out_data must be stable while out_valid=1 and out_ready=0.
  - SEND_Z transfer: frame_done=1 for that cycle, return to GET_A.
- in_ready is 0 in CALC and all SEND states. No frame overlap; input bytes offered there are not consumed.
- Arithmetic (all unsigned, modulo):
  - d = (a+b) mod 2^W
  - e = (a+c) mod 2^W
  - g = (d > e)
  - z = g ? d : e; on equality z=e
  - f = a*c, full 2W bits
  - x = (f - zero-extended d) mod 2^(2W)
- Latency: first output symbol is valid 2 cycles after the c transfer edge (CALC cycle, then SEND_XH). With out_ready held 1, the frame drains in 3 cycles.
- Reset mid-frame: partial operands and results are discarded immediately (asynchronous); out_valid drops in the same instant. The next frame starts fresh at GET_A.
- in_valid and out_ready are independent. in_data is ignored when in_ready=0.

Decomposition:
- Shared package dp_pkg:
  - state encoding typedef (7 states, 3-bit)
  - DP_WIDTH default constant
  - output symbol order constants (XH, XL, Z)
- One natural sub-module: dp_core_comb, the purely combinational a,b,c -> x,z function. Its outputs are registered in CALC by dp_byte_link. Reusable against the golden model in the bench.

Test Plan:
- a=10, b=20, c=3, out_ready=1 -> out stream 0x00, 0x00, 0x1E (x=0, z=30); frame_done on the 3rd output; first out_valid 2 cycles after the c accept.
- a=200, b=100, c=2 (d wraps to 44) -> x=0x0164, z=202 (0xCA); out stream 0x01, 0x64, 0xCA.
- a=1, b=5, c=0 (negative wrap) -> x=0xFFFA, z=6; out stream 0xFF, 0xFA, 0x06.
- a=b=c=255 (d==e) -> x=0xFD03, z=254 (else branch taken); out stream 0xFD, 0x03, 0xFE.
- Backpressure: out_ready toggles 1,0,0,1,0,1 -> each symbol is held stable while stalled; in_ready=0 throughout, with in_valid=1 and junk data offered; the next frame operands are unaffected.
- rst asserted after b is accepted, then frame a=10, b=20, c=3 -> out_valid and busy go 0 immediately; the post-reset frame yields 0x00, 0x00, 0x1E.
